// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if : received-byte bus between the UART receiver and the frame parser -- rev 1.0
`default_nettype none

interface uart_byte_rx_if;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       rx_err;
  logic       rx_busy;

  modport master (output rx_data, rx_flag, rx_err, rx_busy);
  modport slave  (input  rx_data, rx_flag, rx_err, rx_busy);
endinterface

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// uart_byte_rx : oversampling 8N1 UART receiver, one-cycle rx_flag per good byte -- rev 1.0
`default_nettype none

module uart_byte_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           uart_rxd,
  uart_byte_rx_if.master rx
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;
  localparam int CNT_W    = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] BPS_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             rxd_s1, rxd_s2, rxd_d;
  logic             fall;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic [7:0]       data_r, data_nxt;
  logic             flag_r, flag_nxt;
  logic             err_r, err_nxt;
  logic             busy_r;

  // Synchroniser flops reset to the idle-high level so release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
    end
  end

  assign fall = rxd_d & ~rxd_s2;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_r    <= '0;
      flag_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      data_r    <= data_nxt;
      flag_r    <= flag_nxt;
      err_r     <= err_nxt;
      busy_r    <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    data_nxt    = data_r;
    flag_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          // A high line at mid-start is a glitch, not a frame.
          state_nxt   = rxd_s2 ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == BPS_LAST) begin
          clk_cnt_nxt        = '0;
          shift_nxt[bit_cnt] = rxd_s2;
          bit_cnt_nxt        = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == BPS_LAST) begin
          // Leaving at mid-stop leaves half a bit of slack for the next start edge.
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (rxd_s2) begin
            data_nxt = shift_reg;
            flag_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx.rx_data = data_r;
  assign rx.rx_flag = flag_r;
  assign rx.rx_err  = err_r;
  assign rx.rx_busy = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx : randomized scoreboard bench for uart_byte_rx (BPS_CNT=10, HALF_CNT=5) -- rev 1.0
`default_nettype none

module tb_uart_byte_rx;

  logic sys_clk;
  logic sys_rst;
  logic uart_rxd;

  uart_byte_rx_if rx_if ();

  uart_byte_rx #(
    .CLK_FREQ (1000000),
    .UART_BPS (100000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rxd (uart_rxd),
    .rx       (rx_if.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_good = 8'h00;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outcome comes straight from the frame content: good stop -> byte, bad stop -> error.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int p10, input int gap);
    logic [9:0] fr;
    int nc;
    fr = {stop, d, 1'b0};
    if (stop) begin
      exp_q.push_back('{is_err: 1'b0, data: d});
      last_good = d;
    end else begin
      exp_q.push_back('{is_err: 1'b1, data: last_good});
    end
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      nc = ((i + 1) * p10 + 5) / 10 - (i * p10 + 5) / 10;
      for (int c = 0; c < nc; c++) begin
        tick();
        if (i == 4 && c == 0) check("busy_mid_frame", {7'd0, rx_if.rx_busy}, 8'd1);
      end
    end
    uart_rxd = 1'b1;
    repeat (gap) tick();
    if (gap >= 10) check("busy_after_frame", {7'd0, rx_if.rx_busy}, 8'd0);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst) begin
      if (rx_if.rx_flag && rx_if.rx_err) begin
        n_vec++;
        n_err++;
        $display("FAIL flag_and_err: both high, required exclusive at %0t", $time);
      end else if (rx_if.rx_flag || rx_if.rx_err) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: flag=%0b err=%0b data=%02h, required no pulse at %0t",
                   rx_if.rx_flag, rx_if.rx_err, rx_if.rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (rx_if.rx_err !== e.is_err || rx_if.rx_data !== e.data) begin
            n_err++;
            $display("FAIL pulse_content: err=%0b data=%02h, required err=%0b data=%02h at %0t",
                     rx_if.rx_err, rx_if.rx_data, e.is_err, e.data, $time);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] rd;
    logic       rs;
    int         rp;
    int         rg;

    uart_rxd = 1'b1;
    sys_rst  = 1'b0;
    repeat (3) tick();
    check("reset_data", rx_if.rx_data, 8'h00);
    check("reset_flag", {7'd0, rx_if.rx_flag}, 8'd0);
    check("reset_err",  {7'd0, rx_if.rx_err},  8'd0);
    check("reset_busy", {7'd0, rx_if.rx_busy}, 8'd0);
    sys_rst = 1'b1;
    repeat (20) tick();

    send_byte(8'hA5, 1'b1, 100, 20);
    send_byte(8'hEB, 1'b1, 100, 0);
    send_byte(8'h90, 1'b1, 100, 20);

    // Short low glitch: START must abort at mid-sample.
    uart_rxd = 1'b0;
    repeat (3) tick();
    uart_rxd = 1'b1;
    repeat (2) tick();
    check("glitch_busy_high", {7'd0, rx_if.rx_busy}, 8'd1);
    repeat (20) tick();
    check("glitch_busy_low", {7'd0, rx_if.rx_busy}, 8'd0);
    check("glitch_data", rx_if.rx_data, last_good);

    send_byte(8'h3C, 1'b0, 100, 20);
    check("err_data_held", rx_if.rx_data, 8'h90);

    // Reset in the middle of bit 4 of 8'h55.
    uart_rxd = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      rd = 8'h55;
      uart_rxd = rd[i];
      repeat (10) tick();
    end
    uart_rxd = 1'b1;
    repeat (5) tick();
    sys_rst = 1'b0;
    repeat (3) tick();
    last_good = 8'h00;
    check("midreset_data", rx_if.rx_data, 8'h00);
    check("midreset_busy", {7'd0, rx_if.rx_busy}, 8'd0);
    sys_rst = 1'b1;
    repeat (20) tick();
    check("post_reset_busy", {7'd0, rx_if.rx_busy}, 8'd0);

    send_byte(8'h12, 1'b1, 100, 20);
    send_byte(8'hF0, 1'b1, 97, 20);
    send_byte(8'hF0, 1'b1, 103, 20);

    for (int n = 0; n < 16; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rp = int'($urandom_range(97, 103));
      rg = rs ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 15));
      send_byte(rd, rs, rp, rg);
    end

    for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    check("all_expected_seen", 8'(exp_q.size()), 8'd0);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
